// File: rtl/ssd_display_arbiter.sv
// Two-requester arbiter for a 4-digit seven-segment display.
// A new owner keeps the display for at least P_DWELL cycles; the owner may refresh its value in place.
module ssd_display_arbiter #(
  parameter int unsigned P_DWELL = 100000000
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_Req_A,
  input  logic [15:0] i_Data_A,
  output logic        o_Grant_A,
  input  logic        i_Req_B,
  input  logic [15:0] i_Data_B,
  output logic        o_Grant_B,
  output logic [3:0]  o_Digit_1,
  output logic [3:0]  o_Digit_2,
  output logic [3:0]  o_Digit_3,
  output logic [3:0]  o_Digit_4,
  output logic        o_Owner,
  output logic        o_Busy
);

  localparam logic [26:0] C_RELOAD = 27'(P_DWELL - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW_A = 2'd1,
    SHOW_B = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [26:0] cnt_q, cnt_d;
  logic [15:0] data_q, data_d;
  logic        owner_q, owner_d;
  logic        busy_q, busy_d;
  logic        grant_a_q, grant_a_d;
  logic        grant_b_q, grant_b_d;
  logic        ptr_b_q, ptr_b_d;

  logic        req_a_s, req_b_s;
  logic        cur_b_s, own_req_s, oth_req_s;
  logic        do_grant_s, grant_to_b_s, reload_s;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q   <= IDLE;
      cnt_q     <= 27'd0;
      data_q    <= 16'h0000;
      owner_q   <= 1'b0;
      busy_q    <= 1'b0;
      grant_a_q <= 1'b0;
      grant_b_q <= 1'b0;
      ptr_b_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      grant_a_q <= grant_a_d;
      grant_b_q <= grant_b_d;
      ptr_b_q   <= ptr_b_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    owner_d      = owner_q;
    ptr_b_d      = ptr_b_q;
    grant_a_d    = 1'b0;
    grant_b_d    = 1'b0;
    do_grant_s   = 1'b0;
    grant_to_b_s = 1'b0;
    reload_s     = 1'b0;

    // A requester whose grant is currently pulsing is not re-granted back to back.
    req_a_s   = i_Req_A & ~grant_a_q;
    req_b_s   = i_Req_B & ~grant_b_q;
    cur_b_s   = (state_q == SHOW_B);
    own_req_s = cur_b_s ? req_b_s : req_a_s;
    oth_req_s = cur_b_s ? req_a_s : req_b_s;

    case (state_q)
      IDLE: begin
        if (req_a_s && (!req_b_s || !ptr_b_q)) begin
          do_grant_s   = 1'b1;
          grant_to_b_s = 1'b0;
          reload_s     = 1'b1;
        end else if (req_b_s) begin
          do_grant_s   = 1'b1;
          grant_to_b_s = 1'b1;
          reload_s     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SHOW_A, SHOW_B: begin
        if (cnt_q != 27'd0) begin
          cnt_d = cnt_q - 27'd1;
          if (own_req_s) begin
            do_grant_s   = 1'b1;
            grant_to_b_s = cur_b_s;
          end else begin
            do_grant_s = 1'b0;
          end
        end else if (oth_req_s) begin
          do_grant_s   = 1'b1;
          grant_to_b_s = ~cur_b_s;
          reload_s     = 1'b1;
        end else if (own_req_s) begin
          do_grant_s   = 1'b1;
          grant_to_b_s = cur_b_s;
          reload_s     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_grant_s) begin
      data_d    = grant_to_b_s ? i_Data_B : i_Data_A;
      grant_a_d = ~grant_to_b_s;
      grant_b_d = grant_to_b_s;
      owner_d   = grant_to_b_s;
      ptr_b_d   = ~grant_to_b_s;
      state_d   = grant_to_b_s ? SHOW_B : SHOW_A;
      if (reload_s) begin
        cnt_d = C_RELOAD;
      end else begin
        cnt_d = cnt_d;
      end
    end else begin
      data_d = data_q;
    end

    busy_d = (cnt_d != 27'd0);
  end

  assign o_Grant_A = grant_a_q;
  assign o_Grant_B = grant_b_q;
  assign o_Owner   = owner_q;
  assign o_Busy    = busy_q;
  assign o_Digit_1 = data_q[15:12];
  assign o_Digit_2 = data_q[11:8];
  assign o_Digit_3 = data_q[7:4];
  assign o_Digit_4 = data_q[3:0];

endmodule

// File: tb/tb_ssd_display_arbiter.sv
// Bench for ssd_display_arbiter: directed vector table, reset corner cases, then
// protocol-abiding random requests checked against a cycle-level reference model.
module tb_ssd_display_arbiter;

  localparam int unsigned P = 4;

  logic        clk, rst;
  logic        ra, rb;
  logic [15:0] da, db;
  logic        ga, gb, own, busy;
  logic [3:0]  d1, d2, d3, d4;

  int n_vec  = 0;
  int n_miss = 0;

  ssd_display_arbiter #(.P_DWELL(P)) dut (
    .i_CLK(clk), .i_RST(rst),
    .i_Req_A(ra), .i_Data_A(da), .o_Grant_A(ga),
    .i_Req_B(rb), .i_Data_B(db), .o_Grant_B(gb),
    .o_Digit_1(d1), .o_Digit_2(d2), .o_Digit_3(d3), .o_Digit_4(d4),
    .o_Owner(own), .o_Busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ra, rb;
    logic [15:0] da, db;
    logic        ga, gb, own, busy;
    logic [15:0] dig;
  } vec_t;

  vec_t tbl[32];

  // Reference model: who holds the display, how many dwell cycles remain, last winner.
  bit          m_act;
  int          m_own, m_rem, m_last;
  logic [15:0] m_dat;
  bit          m_g[2];

  function automatic void model_reset();
    m_act = 0; m_own = 0; m_rem = 0; m_last = -1; m_dat = 16'h0000;
    m_g[0] = 0; m_g[1] = 0;
  endfunction

  function automatic void model_step(bit a, bit b, logic [15:0] xa, logic [15:0] xb);
    bit          want[2];
    logic [15:0] dv[2];
    int          pick;
    bit          reload;
    pick = -1; reload = 0;
    want[0] = a && !m_g[0]; want[1] = b && !m_g[1];
    dv[0] = xa; dv[1] = xb;
    if (!m_act) begin
      reload = 1;
      if (want[0] && want[1]) pick = (m_last == 0) ? 1 : 0;
      else if (want[0]) pick = 0;
      else if (want[1]) pick = 1;
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1;
      if (want[m_own]) pick = m_own;
    end else if (want[1 - m_own]) begin
      pick = 1 - m_own; reload = 1;
    end else if (want[m_own]) begin
      pick = m_own; reload = 1;
    end else begin
      m_act = 0;
    end
    m_g[0] = 0; m_g[1] = 0;
    if (pick >= 0) begin
      m_g[pick] = 1; m_dat = dv[pick]; m_own = pick; m_last = pick; m_act = 1;
      if (reload) m_rem = P - 1;
    end
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(string tag, logic e_ga, logic e_gb, logic e_own, logic e_busy, logic [15:0] e_dig);
    chk({tag, ".grant_a"}, int'(ga), int'(e_ga));
    chk({tag, ".grant_b"}, int'(gb), int'(e_gb));
    chk({tag, ".owner"}, int'(own), int'(e_own));
    chk({tag, ".busy"}, int'(busy), int'(e_busy));
    chk({tag, ".digits"}, int'({d1, d2, d3, d4}), int'(e_dig));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(ra, rb, da, db);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic vec_t mk(logic a, logic b, logic [15:0] xa, logic [15:0] xb,
                              logic e_ga, logic e_gb, logic e_own, logic e_busy, logic [15:0] e_dig);
    vec_t v;
    v.ra = a; v.rb = b; v.da = xa; v.db = xb;
    v.ga = e_ga; v.gb = e_gb; v.own = e_own; v.busy = e_busy; v.dig = e_dig;
    return v;
  endfunction

  initial begin
    tbl[0]  = mk(1'b1, 1'b0, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234);
    tbl[1]  = mk(1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234);
    tbl[2]  = mk(1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234);
    tbl[3]  = mk(1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234);
    tbl[4]  = mk(1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234);
    tbl[5]  = mk(1'b1, 1'b1, 16'h1111, 16'hABCD, 1'b0, 1'b1, 1'b1, 1'b1, 16'hABCD);
    tbl[6]  = mk(1'b1, 1'b0, 16'h1111, 16'hABCD, 1'b0, 1'b0, 1'b1, 1'b1, 16'hABCD);
    tbl[7]  = mk(1'b1, 1'b1, 16'h1111, 16'h5678, 1'b0, 1'b1, 1'b1, 1'b1, 16'h5678);
    tbl[8]  = mk(1'b1, 1'b0, 16'h1111, 16'h5678, 1'b0, 1'b0, 1'b1, 1'b0, 16'h5678);
    tbl[9]  = mk(1'b1, 1'b0, 16'h2222, 16'h5678, 1'b1, 1'b0, 1'b0, 1'b1, 16'h2222);
    tbl[10] = mk(1'b0, 1'b0, 16'h2222, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h2222);
    tbl[11] = mk(1'b0, 1'b0, 16'h2222, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h2222);
    tbl[12] = mk(1'b1, 1'b0, 16'h3333, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h3333);
    tbl[13] = mk(1'b1, 1'b0, 16'h3333, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3333);
    tbl[14] = mk(1'b1, 1'b0, 16'h4444, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h4444);
    tbl[15] = mk(1'b0, 1'b0, 16'h4444, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4444);
    tbl[16] = mk(1'b0, 1'b0, 16'h4444, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4444);
    tbl[17] = mk(1'b0, 1'b0, 16'h4444, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4444);
    tbl[18] = mk(1'b1, 1'b1, 16'h5555, 16'h6666, 1'b0, 1'b1, 1'b1, 1'b1, 16'h6666);
    tbl[19] = mk(1'b1, 1'b0, 16'h5555, 16'h6666, 1'b0, 1'b0, 1'b1, 1'b1, 16'h6666);
    tbl[20] = mk(1'b1, 1'b0, 16'h5555, 16'h6666, 1'b0, 1'b0, 1'b1, 1'b1, 16'h6666);
    tbl[21] = mk(1'b1, 1'b0, 16'h5555, 16'h6666, 1'b0, 1'b0, 1'b1, 1'b0, 16'h6666);
    tbl[22] = mk(1'b1, 1'b0, 16'h5555, 16'h6666, 1'b1, 1'b0, 1'b0, 1'b1, 16'h5555);
    tbl[23] = mk(1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5555);
    tbl[24] = mk(1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5555);
    tbl[25] = mk(1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h5555);
    tbl[26] = mk(1'b1, 1'b0, 16'h7777, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h7777);
    tbl[27] = mk(1'b0, 1'b0, 16'h7777, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7777);
    tbl[28] = mk(1'b0, 1'b0, 16'h7777, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7777);
    tbl[29] = mk(1'b0, 1'b0, 16'h7777, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7777);
    tbl[30] = mk(1'b0, 1'b0, 16'h7777, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7777);
    tbl[31] = mk(1'b0, 1'b1, 16'h0000, 16'hBEEF, 1'b0, 1'b1, 1'b1, 1'b1, 16'hBEEF);

    ra = 1'b0; rb = 1'b0; da = 16'h0000; db = 16'h0000;
    rst = 1'b1;
    model_reset();
    #12;
    chk_all("reset_state", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    do_reset();

    for (int i = 0; i < 32; i++) begin
      ra = tbl[i].ra; rb = tbl[i].rb; da = tbl[i].da; db = tbl[i].db;
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].ga, tbl[i].gb, tbl[i].own, tbl[i].busy, tbl[i].dig);
    end

    // Simultaneous requests right after reset: A wins, B waits out the dwell.
    ra = 1'b0; rb = 1'b0;
    do_reset();
    ra = 1'b1; rb = 1'b1; da = 16'h2468; db = 16'hABCD;
    tick(); chk_all("both_after_reset", 1'b1, 1'b0, 1'b0, 1'b1, 16'h2468);
    ra = 1'b0;
    tick(); chk_all("b_wait1", 1'b0, 1'b0, 1'b0, 1'b1, 16'h2468);
    tick(); chk_all("b_wait2", 1'b0, 1'b0, 1'b0, 1'b1, 16'h2468);
    tick(); chk_all("b_wait3", 1'b0, 1'b0, 1'b0, 1'b0, 16'h2468);
    tick(); chk_all("b_granted", 1'b0, 1'b1, 1'b1, 1'b1, 16'hABCD);
    rb = 1'b0;
    tick(); chk_all("b_dwell", 1'b0, 1'b0, 1'b1, 1'b1, 16'hABCD);

    // Asynchronous reset between edges mid-dwell, then a held B request is granted first edge.
    #3 rst = 1'b1;
    #1 chk_all("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    rb = 1'b1; db = 16'h4321;
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    tick(); chk_all("post_reset_b", 1'b0, 1'b1, 1'b1, 1'b1, 16'h4321);
    rb = 1'b0;

    // Random requesters that hold their request until they see their grant.
    for (int c = 0; c < 600; c++) begin
      if (m_g[0]) ra = 1'b0;
      else if (!ra && $urandom_range(0, 3) == 0) ra = 1'b1;
      if (m_g[1]) rb = 1'b0;
      else if (!rb && $urandom_range(0, 3) == 0) rb = 1'b1;
      if ($urandom_range(0, 1) == 0) da = 16'($urandom);
      if ($urandom_range(0, 1) == 0) db = 16'($urandom);
      tick();
      chk_all($sformatf("rand%0d", c), m_g[0], m_g[1], 1'(m_own), (m_rem != 0), m_dat);
      chk("grant_mutex", int'(ga & gb), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ssd_display_arbiter.md
SSD_DISPLAY_ARBITER -- requirements
Module: ssd_display_arbiter

Interface
REQ-001 Parameter: P_DWELL, default 100000000, minimum display hold in i_CLK cycles after an owner change; legal range 2..2^27-1.
REQ-002 Port: i_CLK  in  1  system clock; all state updates on rising edge.
REQ-003 Port: i_RST  in  1  reset, asynchronous, active-high.
REQ-004 Port: i_Req_A  in  1  requester A wants the display; held until o_Grant_A observed.
REQ-005 Port: i_Data_A  in  16  requester A value; [15:12] leftmost digit ... [3:0] rightmost.
REQ-006 Port: o_Grant_A  out  1  one-cycle pulse; i_Data_A was latched on the edge that raised it.
REQ-007 Port: i_Req_B  in  1  as i_Req_A, for requester B.
REQ-008 Port: i_Data_B  in  16  as i_Data_A, for requester B.
REQ-009 Port: o_Grant_B  out  1  as o_Grant_A, for requester B.
REQ-010 Port: o_Digit_1..o_Digit_4  out  4 each  registered digits to display mux; Digit_1=[15:12], Digit_4=[3:0].
REQ-011 Port: o_Owner  out  1  current display owner (0=A, 1=B).
REQ-012 Port: o_Busy  out  1  high while dwell counter nonzero (owner locked).

Function
REQ-013 State machine SHALL have states IDLE, SHOW_A, SHOW_B; all outputs registered.
REQ-014 Grant latency SHALL be one cycle: request sampled high at edge N -> grant high and digits updated from edge N to N+1.
REQ-015 Grant pulse SHALL be exactly one cycle; a request is ignored in any cycle where that requester's grant is high, so no requester is granted on consecutive cycles.
REQ-016 o_Grant_A and o_Grant_B SHALL never be high in the same cycle.
REQ-017 IDLE, single request: grant it, latch its data, set o_Owner, load dwell counter with P_DWELL-1, go to SHOW_x.
REQ-018 IDLE, both requests: grant the requester that is not the last owner (round-robin pointer); after reset the pointer favours A.
REQ-019 SHOW_x, counter nonzero: counter decrements by 1 per cycle; other requester SHALL wait (no grant).
REQ-020 SHOW_x, counter nonzero, owner request: grant owner, latch new data, do NOT reload counter (in-place update).
REQ-021 SHOW_x, counter zero, other requester asserting (regardless of owner request): grant other, switch owner, reload P_DWELL-1, go to SHOW_other.
REQ-022 SHOW_x, counter zero, only owner asserting: grant owner, latch data, reload P_DWELL-1, stay.
REQ-023 SHOW_x, counter zero, no request: go to IDLE; digits and o_Owner hold last values.
REQ-024 o_Busy SHALL equal (counter != 0); counter SHALL be 27 bits and never wrap below zero.
REQ-025 Round-robin pointer SHALL update to the granted requester on every owner change.
REQ-026 Data inputs SHALL be sampled only on the granting edge; changes at other times SHALL not affect outputs.

Reset
REQ-027 While i_RST high, regardless of clock: state IDLE, all digits 0, o_Grant_A/B 0, o_Owner 0, o_Busy 0, counter 0, pointer favours A.
REQ-028 Reset asserted mid-dwell or during a grant pulse SHALL abort immediately; pending requests are re-arbitrated from IDLE on the first edge after release.

Verification (P_DWELL=4)
REQ-029 Reset, then i_Req_A=1, i_Data_A=16'h1234 -> next cycle o_Grant_A=1 one cycle, digits 1,2,3,4, o_Owner=0, o_Busy=1 for 3 cycles.
REQ-030 From IDLE after reset, i_Req_A and i_Req_B high same edge, i_Data_B=16'hABCD -> o_Grant_A first; B granted only when counter reaches 0, digits A,B,C,D, o_Owner=1.
REQ-031 Owner A mid-dwell requests with 16'h5678 -> o_Grant_A next cycle, digits 5,6,7,8, counter continues (not reloaded).
REQ-032 SHOW_A counter zero, both requests high -> o_Grant_B, o_Owner=1; A granted after B's dwell expires.
REQ-033 Dwell expiry with no requests -> IDLE, digits hold last value, o_Busy=0, no grant pulses.
REQ-034 Assert i_Rst asynchronously (between edges) mid-dwell with B owner -> all outputs zero immediately; after release a held i_Req_B is granted on first edge.
